// File: rtl/hamming_in.sv
// Serial-in front end of the Hamming(15,11) chain: assembles 11-bit frames from
// sl_in, encodes them combinationally and latches the codeword at each frame end.

module hamming_in_enc (
  input  logic [10:0] data,
  output logic [14:0] cw
);
  // Bit k of a position number selects which parity group that position joins.
  localparam logic [3:0][14:0] PAR_MASK = {15'h7F80, 15'h7878, 15'h6666, 15'h5555};

  logic [14:0] base;
  logic [3:0]  par;

  assign base = {data[10:4], 1'b0, data[3:1], 1'b0, data[0], 2'b00};

  always_comb begin
    par = '0;
    for (int k = 0; k < 4; k++) par[k] = ^(base & PAR_MASK[k]);
    cw    = base;
    cw[0] = par[0];
    cw[1] = par[1];
    cw[3] = par[2];
    cw[7] = par[3];
  end
endmodule

module hamming_in (
  input  logic        clk,
  input  logic        RST,
  input  logic        shift,
  input  logic        sl_in,
  output logic [10:0] datall,
  output logic [14:0] hammingout,
  output logic [14:0] finalout,
  output logic        countfull,
  output logic        data_out
);
  localparam int NUM_ENC = 2;

  logic [3:0]                 cnt;
  logic [NUM_ENC-1:0][10:0]   enc_data;
  logic [NUM_ENC-1:0][14:0]   enc_cw;

  // Slot 0 encodes the visible word; slot 1 encodes the word the next shift would form,
  // so finalout can capture the completed frame on the same edge.
  assign enc_data = {{datall[9:0], sl_in}, datall};

  for (genvar i = 0; i < NUM_ENC; i++) begin : g_enc
    hamming_in_enc u_enc (.data(enc_data[i]), .cw(enc_cw[i]));
  end

  assign hammingout = enc_cw[0];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      datall    <= '0;
      cnt       <= '0;
      finalout  <= '0;
      countfull <= 1'b0;
      data_out  <= 1'b0;
    end else begin
      countfull <= 1'b0;
      if (shift) begin
        datall   <= enc_data[1];
        data_out <= datall[10];
        if (cnt == 4'd10) begin
          cnt       <= '0;
          countfull <= 1'b1;
          finalout  <= enc_cw[1];
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hamming_in.sv
// Bench for hamming_in: bit-history reference model compared every cycle, plus
// directed reference-frame, corner, stall, back-to-back and mid-frame-reset checks.

module tb_hamming_in;
  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        shift = 1'b0;
  logic        sl_in = 1'b0;
  logic [10:0] datall;
  logic [14:0] hammingout;
  logic [14:0] finalout;
  logic        countfull;
  logic        data_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;

  hamming_in dut (
    .clk(clk), .RST(RST), .shift(shift), .sl_in(sl_in),
    .datall(datall), .hammingout(hammingout), .finalout(finalout),
    .countfull(countfull), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: the full history of accepted bits since the last reset.
  logic hist[$];
  int   n = 0;
  logic last_shift = 1'b0;

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      hist.delete();
      n = 0;
      last_shift = 1'b0;
    end else begin
      last_shift = shift;
      if (shift) begin
        hist.push_back(sl_in);
        n++;
      end
    end
  end

  // Hamming(15,11) by position: data fills non-power-of-two slots, then each
  // parity bit makes its group even.
  function automatic logic [14:0] enc(input logic [10:0] d);
    logic [14:0] c;
    int j;
    logic p;
    c = '0;
    j = 0;
    for (int pos = 1; pos <= 15; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos >> b) & 1) == 1 && pos != (1 << b)) p ^= c[pos-1];
      c[(1 << b) - 1] = p;
    end
    return c;
  endfunction

  function automatic logic [10:0] word_at(input int m);
    logic [10:0] w;
    w = '0;
    for (int i = 0; i < 11; i++)
      if (m - 1 - i >= 0) w[i] = hist[m-1-i];
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [10:0] e_d;
    logic [14:0] e_f;
    e_d = word_at(n);
    e_f = (n >= 11) ? enc(word_at((n / 11) * 11)) : 15'h0;
    check("datall", 32'(datall), 32'(e_d));
    check("hammingout", 32'(hammingout), 32'(enc(e_d)));
    check("finalout", 32'(finalout), 32'(e_f));
    check("countfull", 32'(countfull), 32'(last_shift && n > 0 && (n % 11) == 0));
    check("data_out", 32'(data_out), 32'((n >= 12) ? hist[n-12] : 1'b0));
    if (countfull) begin
      pulses++;
      last_pulse = cyc;
    end
  end

  task automatic step(input logic s, input logic b);
    @(negedge clk); #1;
    shift = s;
    sl_in = b;
  endtask

  task automatic look();
    @(negedge clk); #2;
    shift = 1'b0;
  endtask

  task automatic shift_word(input logic [10:0] w);
    for (int i = 10; i >= 0; i--) step(1'b1, w[i]);
  endtask

  logic [10:0] wa, wb;
  logic [21:0] bits22;
  int start, p0;

  initial begin
    // Reset held with shift active and data toggling.
    for (int i = 0; i < 5; i++) step(1'b1, i[0]);
    look();
    check("rst_datall", 32'(datall), 32'h0);
    check("rst_finalout", 32'(finalout), 32'h0);
    check("rst_pulses", 32'(pulses), 32'h0);

    // Reference frame; model pinned by literal.
    check("model_ref", 32'(enc(11'h4BD)), 32'h4B66);
    step(1'b0, 1'b0);
    RST = 1'b1;
    start = cyc + 2;
    shift_word(11'h4BD);
    look();
    check("ref_datall", 32'(datall), 32'h4BD);
    check("ref_hammingout", 32'(hammingout), 32'h4B66);
    check("ref_finalout", 32'(finalout), 32'h4B66);
    check("ref_countfull", 32'(countfull), 32'h1);
    check("ref_pulse_edge", 32'(last_pulse), 32'(start + 10));
    look();
    check("ref_countfull_drop", 32'(countfull), 32'h0);

    // Encoder corners.
    shift_word(11'h7FF); look(); check("corner_7ff", 32'(hammingout), 32'h7FFF);
    shift_word(11'h000); look(); check("corner_000", 32'(hammingout), 32'h0000);
    shift_word(11'h001); look(); check("corner_001", 32'(hammingout), 32'h0007);
    shift_word(11'h400); look(); check("corner_400", 32'(hammingout), 32'h408B);
    check("model_400", 32'(enc(11'h400)), 32'h408B);

    // Stall: 6 bits, 5 idle cycles, 5 bits.
    wa = 11'($urandom);
    p0 = pulses;
    step(1'b1, wa[10]);
    start = cyc + 1;
    for (int i = 9; i >= 5; i--) step(1'b1, wa[i]);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    for (int i = 4; i >= 0; i--) step(1'b1, wa[i]);
    look();
    check("stall_pulse_edge", 32'(last_pulse), 32'(start + 15));
    check("stall_pulses", 32'(pulses - p0), 32'h1);
    check("stall_finalout", 32'(finalout), 32'(enc(wa)));

    // Back-to-back frames.
    bits22 = 22'($urandom);
    wa = bits22[21:11];
    wb = bits22[10:0];
    p0 = pulses;
    for (int i = 0; i < 22; i++) begin
      step(1'b1, bits22[21-i]);
      if (i == 0) start = cyc + 1;
      if (i == 11) check("b2b_finalout1", 32'(finalout), 32'(enc(wa)));
      if (i >= 12) check("b2b_data_out", 32'(data_out), 32'(bits22[21-(i-12)]));
    end
    look();
    check("b2b_pulses", 32'(pulses - p0), 32'h2);
    check("b2b_pulse2_edge", 32'(last_pulse), 32'(start + 21));
    check("b2b_finalout2", 32'(finalout), 32'(enc(wb)));

    // Mid-frame reset.
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom));
    @(negedge clk); #1;
    RST = 1'b0;
    shift = 1'b1;
    look();
    check("midrst_finalout", 32'(finalout), 32'h0);
    @(negedge clk); #1;
    RST = 1'b1;
    wb = 11'($urandom);
    p0 = pulses;
    step(1'b1, wb[10]);
    start = cyc + 1;
    for (int i = 9; i >= 0; i--) step(1'b1, wb[i]);
    look();
    check("midrst_pulses", 32'(pulses - p0), 32'h1);
    check("midrst_pulse_edge", 32'(last_pulse), 32'(start + 10));
    check("midrst_finalout2", 32'(finalout), 32'(enc(wb)));

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      shift = ($urandom_range(3) != 0);
      sl_in = 1'($urandom);
      RST = ($urandom_range(199) != 0);
    end
    @(negedge clk); #1;
    RST = 1'b1;
    shift = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
